// File: rtl/program_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// program_sequencer_pkg
//   Shared definitions for the program sequencer of the 8-bit core:
//   program-memory address width, jump-target shift, reset vector, the
//   program-counter type and a helper that forms a jump target from the
//   decoder's instruction nibble.
// ----------------------------------------------------------------------------
package program_sequencer_pkg;

  localparam int PM_ADDR_W     = 8;
  localparam int JMP_TGT_SHIFT = 4;

  typedef logic [PM_ADDR_W-1:0] pc_t;

  localparam pc_t RESET_VECTOR = 8'h00;

  // Jump targets are always 16-byte aligned: {nibble, 4'h0}.
  function automatic pc_t jump_target(input logic [3:0] nibble);
    return pc_t'(nibble) << JMP_TGT_SHIFT;
  endfunction

endpackage : program_sequencer_pkg

// File: rtl/program_sequencer_jump_trace_buf.sv
// ----------------------------------------------------------------------------
// jump_trace_buf
//   Ring buffer recording the pc of every taken jump, with a registered,
//   newest-first read port.
//
//   Ports
//     clk         in   clock, all state on posedge
//     sync_reset  in   synchronous active-high reset (empties the ring)
//     wr_en       in   record wr_data this cycle (a taken jump)
//     wr_data     in   pc of the jump instruction
//     rd_idx      in   0 = most recent entry, 1 = the one before, ...
//     rd_data     out  selected entry, 0 when rd_idx is beyond the fill level
//     rd_valid    out  rd_data holds a recorded entry
//
//   DEPTH must be a power of two in 2..16 so the pointers wrap naturally.
//   A read in the same cycle as a write returns the pre-write contents.
// ----------------------------------------------------------------------------
module jump_trace_buf
  import program_sequencer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       sync_reset,
  input  logic       wr_en,
  input  pc_t        wr_data,
  input  logic [3:0] rd_idx,
  output pc_t        rd_data,
  output logic       rd_valid
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = $clog2(DEPTH + 1);

  pc_t              mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [PTR_W-1:0] rd_ptr;
  pc_t              rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    rd_ptr     = wr_ptr_q - PTR_W'(1) - rd_idx[PTR_W-1:0];
    rd_valid_d = int'(rd_idx) < int'(fill_q);
    rd_data_d  = '0;

    if (rd_valid_d) begin
      rd_data_d = mem_q[rd_ptr];
    end

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      // Fill saturates at DEPTH; further writes overwrite the oldest entry.
      if (fill_q != FILL_W'(DEPTH)) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read once
  // fill_q says it was written, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule : jump_trace_buf

// File: rtl/program_sequencer.sv
// ----------------------------------------------------------------------------
// program_sequencer
//   Generates the program-memory address for the 8-bit core. Program memory
//   returns next_instr for pm_addr and the decoder registers it into ir, so
//   pm_addr is combinational and pc follows it one cycle later.
//
//   Ports
//     clk           in   single clock, all state on posedge
//     sync_reset    in   synchronous active-high reset
//     jmp           in   unconditional jump
//     jmp_nz        in   conditional jump, suppressed by dont_jmp
//     jump_addr     in   ir nibble; target = {jump_addr, 4'h0}
//     dont_jmp      in   ALU zero flag
//     pm_addr       out  next program-memory address (combinational)
//     pc            out  current program counter
//     halted        out  program is spinning on a jump-to-self
//     taken_cnt     out  saturating count of taken jumps
//     trace_rd_idx  in   trace read index, 0 = most recent taken jump
//     trace_data    out  pc of the selected taken jump (1-cycle latency)
//     trace_valid   out  trace_data holds a recorded entry
//     from_PS       out  debug tap, equals pc
//
//   Build option PS_TRACE_EN: when defined, the jump-trace ring is built.
//   When undefined, trace_data/trace_valid are tied to zero and
//   trace_rd_idx is ignored.
// ----------------------------------------------------------------------------
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int TRACE_DEPTH = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             jmp,
  input  logic             jmp_nz,
  input  logic [3:0]       jump_addr,
  input  logic             dont_jmp,
  output logic [7:0]       pm_addr,
  output logic [7:0]       pc,
  output logic             halted,
  output logic [CNT_W-1:0] taken_cnt,
  input  logic [3:0]       trace_rd_idx,
  output logic [7:0]       trace_data,
  output logic             trace_valid,
  output logic [7:0]       from_PS
);

  pc_t              pc_q, pc_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  pc_t              target;
  logic             taken;

  always_comb begin
    // NOTE: combinational logic uses blocking '=' so later lines see the
    // values computed above them; registers below use '<=' only.
    target = jump_target(jump_addr);
    // jmp overrides the zero-flag qualification when both are asserted.
    taken  = !sync_reset && (jmp || (jmp_nz && !dont_jmp));

    if (sync_reset) begin
      pm_addr = RESET_VECTOR;
    end else if (taken) begin
      pm_addr = target;
    end else begin
      pm_addr = pc_q + 8'd1;   // wraps 8'hFF -> 8'h00
    end

    pc_d     = pm_addr;
    halted_d = taken && (target == pc_q);

    taken_cnt_d = taken_cnt_q;
    if (taken && (taken_cnt_q != '1)) begin
      taken_cnt_d = taken_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      pc_q        <= RESET_VECTOR;
      halted_q    <= 1'b0;
      taken_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      halted_q    <= halted_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign pc        = pc_q;
  assign from_PS   = pc_q;
  assign halted    = halted_q;
  assign taken_cnt = taken_cnt_q;

`ifdef PS_TRACE_EN
  jump_trace_buf #(
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk        (clk),
    .sync_reset (sync_reset),
    .wr_en      (taken),
    .wr_data    (pc_q),
    .rd_idx     (trace_rd_idx),
    .rd_data    (trace_data),
    .rd_valid   (trace_valid)
  );
`else
  // No trace storage: the read index and depth have no effect.
  logic trace_unused;
  assign trace_unused = ^{trace_rd_idx, 5'(TRACE_DEPTH)};
  assign trace_data   = 8'h00;
  assign trace_valid  = 1'b0;
`endif

endmodule : program_sequencer

// File: tb/tb_program_sequencer.sv
module tb_program_sequencer;

  localparam int DEPTH   = 8;
  localparam int CNT_W   = 4;    // narrow so saturation is reached quickly
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PS_TRACE_EN
  localparam bit TRACE_ON = 1'b1;
`else
  localparam bit TRACE_ON = 1'b0;
`endif

  logic             clk;
  logic             sync_reset;
  logic             jmp;
  logic             jmp_nz;
  logic [3:0]       jump_addr;
  logic             dont_jmp;
  logic [7:0]       pm_addr;
  logic [7:0]       pc;
  logic             halted;
  logic [CNT_W-1:0] taken_cnt;
  logic [3:0]       trace_rd_idx;
  logic [7:0]       trace_data;
  logic             trace_valid;
  logic [7:0]       from_PS;

  program_sequencer #(
    .TRACE_DEPTH (DEPTH),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .sync_reset   (sync_reset),
    .jmp          (jmp),
    .jmp_nz       (jmp_nz),
    .jump_addr    (jump_addr),
    .dont_jmp     (dont_jmp),
    .pm_addr      (pm_addr),
    .pc           (pc),
    .halted       (halted),
    .taken_cnt    (taken_cnt),
    .trace_rd_idx (trace_rd_idx),
    .trace_data   (trace_data),
    .trace_valid  (trace_valid),
    .from_PS      (from_PS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: program counter as an integer, jump history as a
  // newest-first queue capped at DEPTH entries.
  int m_pc;
  bit m_halt;
  int m_cnt;
  int m_hist[$];
  int m_tdata;
  bit m_tvalid;

  // One clock cycle: drive inputs, check the combinational address, clock,
  // advance the model, then check every registered output.
  task automatic step(input logic r, input logic j, input logic jn, input logic dj,
                      input logic [3:0] a, input logic [3:0] idx,
                      output logic [7:0] pm_seen);
    bit tk;
    int tgt;
    int exp_pm;
    sync_reset   = r;
    jmp          = j;
    jmp_nz       = jn;
    dont_jmp     = dj;
    jump_addr    = a;
    trace_rd_idx = idx;
    tk     = !r && (j || (jn && !dj));
    tgt    = int'(a) * 16;
    exp_pm = r ? 0 : (tk ? tgt : (m_pc + 1) % 256);
    #1;
    pm_seen = pm_addr;
    check("pm_addr", 32'(pm_addr), 32'(exp_pm));
    @(posedge clk);
    if (r) begin
      m_pc = 0; m_halt = 0; m_cnt = 0; m_tdata = 0; m_tvalid = 0;
      m_hist.delete();
    end else begin
      if (TRACE_ON && int'(idx) < m_hist.size()) begin
        m_tdata  = m_hist[idx];
        m_tvalid = 1;
      end else begin
        m_tdata  = 0;
        m_tvalid = 0;
      end
      m_halt = tk && (tgt == m_pc);
      if (tk && m_cnt < CNT_MAX) m_cnt++;
      if (tk) begin
        m_hist.push_front(m_pc);
        if (m_hist.size() > DEPTH) void'(m_hist.pop_back());
      end
      m_pc = exp_pm;
    end
    #1;
    check("pc", 32'(pc), 32'(m_pc));
    check("from_PS", 32'(from_PS), 32'(m_pc));
    check("halted", 32'(halted), 32'(m_halt));
    check("taken_cnt", 32'(taken_cnt), 32'(m_cnt));
    check("trace_data", 32'(trace_data), 32'(m_tdata));
    check("trace_valid", 32'(trace_valid), 32'(m_tvalid));
  endtask

  typedef struct {
    logic       rst, j, jn, dj;
    logic [3:0] a;
    logic [7:0] exp_pm;
    logic [7:0] exp_pc;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[11];
  logic [7:0] pm_seen;
  int cnt_before;

  initial begin
    sync_reset = 1'b1; jmp = 1'b0; jmp_nz = 1'b0; dont_jmp = 1'b0;
    jump_addr = 4'h0; trace_rd_idx = 4'h0;
    m_pc = 0; m_halt = 0; m_cnt = 0; m_tdata = 0; m_tvalid = 0;

    // Reset, linear fetch, unconditional and conditional jumps.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h01, 8'h01, 0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h02, 8'h02, 0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h03, 8'h03, 0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h04, 8'h04, 0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h05, 8'h05, 0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 8'h30, 8'h30, 1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 8'h10, 8'h10, 2};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h2, 8'h11, 8'h11, 2};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 8'h20, 8'h20, 3};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 8'hF0, 8'hF0, 4};

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].rst, vecs[i].j, vecs[i].jn, vecs[i].dj, vecs[i].a, 4'h0, pm_seen);
      check($sformatf("tbl%0d_pm", i), 32'(pm_seen), 32'(vecs[i].exp_pm));
      check($sformatf("tbl%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
      check($sformatf("tbl%0d_cnt", i), 32'(taken_cnt), 32'(vecs[i].exp_cnt));
      check($sformatf("tbl%0d_halt", i), 32'(halted), 32'(0));
    end

    // Address wrap: walk from F0 to FF, then one more fetch wraps to 00.
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, pm_seen);
    check("wrap_pc_ff", 32'(pc), 32'hFF);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, pm_seen);
    check("wrap_pm", 32'(pm_seen), 32'h00);
    check("wrap_pc", 32'(pc), 32'h00);

    // Self-jump halt at 8'h40.
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'h4, 4'h0, pm_seen);
    check("halt_enter_pc", 32'(pc), 32'h40);
    check("halt_not_yet", 32'(halted), 32'(0));
    for (int i = 0; i < 3; i++) begin
      cnt_before = int'(taken_cnt);
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'h4, 4'h0, pm_seen);
      check("halt_set", 32'(halted), 32'(1));
      check("halt_cnt_inc", 32'(taken_cnt), 32'(cnt_before + 1));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 4'h0, pm_seen);
    check("halt_clear", 32'(halted), 32'(0));
    check("halt_clear_pc", 32'(pc), 32'h41);

    // Counter saturation: keep spinning well past 2^CNT_W-1 taken jumps.
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 4'h4, 4'h0, pm_seen);
    check("cnt_saturated", 32'(taken_cnt), 32'(CNT_MAX));
    check("cnt_sat_halt", 32'(halted), 32'(1));

    // Trace: ten taken jumps issued from pcs 1..10, each jumping back to 00.
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, pm_seen);
    for (int k = 1; k <= 10; k++) begin
      for (int s = 0; s < k; s++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, pm_seen);
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, pm_seen);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'd0, pm_seen);
    check("trace_idx0_data", 32'(trace_data), TRACE_ON ? 32'd10 : 32'd0);
    check("trace_idx0_valid", 32'(trace_valid), 32'(TRACE_ON));
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'd7, pm_seen);
    check("trace_idx7_data", 32'(trace_data), TRACE_ON ? 32'd3 : 32'd0);
    check("trace_idx7_valid", 32'(trace_valid), 32'(TRACE_ON));
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'd8, pm_seen);
    check("trace_idx8_data", 32'(trace_data), 32'd0);
    check("trace_idx8_valid", 32'(trace_valid), 32'd0);

    // Reset mid-run: address forced to 0 in the same cycle, trace emptied.
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h7, 4'd0, pm_seen);
    check("rst_pm_same_cycle", 32'(pm_seen), 32'h00);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'(i), pm_seen);
      check($sformatf("rst_trace_idx%0d_valid", i), 32'(trace_valid), 32'd0);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic r, j, jn, dj;
      logic [3:0] a, idx;
      r   = ($urandom_range(0, 39) == 0);
      j   = ($urandom_range(0, 3) == 0);
      jn  = 1'($urandom_range(0, 1));
      dj  = 1'($urandom_range(0, 1));
      a   = 4'($urandom_range(0, 15));
      idx = 4'($urandom_range(0, 15));
      // Steer toward jump-to-self now and then so halted gets exercised.
      if ((m_pc % 16) == 0 && $urandom_range(0, 1) == 1) a = 4'(m_pc / 16);
      step(r, j, jn, dj, a, idx, pm_seen);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_program_sequencer
